hexbs_frame_scheduler: RTL and testbench

//  Frame-level sequencer in front of hexbs_top: on frame_start it walks every MB of one frame
//  in raster order, drives the engine's start, addresses and MB position, and waits for done.

---
 rtl/hexbs_frame_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_hexbs_frame_scheduler.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hexbs_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hexbs_frame_scheduler                                           |
// | Purpose  : Walks every MB of one frame in raster order through hexbs_top,  |
// |            streams each MV/SAD result and accumulates the frame SAD total. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hexbs_frame_scheduler #(
  parameter int unsigned FRAME_WIDTH  = 352,
  parameter int unsigned FRAME_HEIGHT = 240,
  parameter int unsigned MB_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYC  = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [15:0]       frame_idx,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       total_sad,
  output logic              err_timeout,
  output logic              err_frame,
  output logic              me_start,
  output logic [31:0]       me_frame_start_addr,
  output logic [31:0]       me_ref_start_addr,
  output logic [31:0]       me_mb_x,
  output logic [31:0]       me_mb_y,
  input  logic signed [5:0] me_mv_x,
  input  logic signed [5:0] me_mv_y,
  input  logic [15:0]       me_sad,
  input  logic              me_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_mb_row,
  output logic [7:0]        res_mb_col,
  output logic signed [5:0] res_mv_x,
  output logic signed [5:0] res_mv_y,
  output logic [15:0]       res_sad
);

  localparam int unsigned c_mb_cols      = FRAME_WIDTH / MB_SIZE;
  localparam int unsigned c_mb_rows      = FRAME_HEIGHT / MB_SIZE;
  localparam logic [31:0] c_frame_pixels = 32'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [7:0]  c_col_last     = 8'(c_mb_cols - 1);
  localparam logic [7:0]  c_row_last     = 8'(c_mb_rows - 1);
  localparam logic [31:0] c_wait_last    = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_EMIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_col;
  logic [7:0]  r_row;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_frame_addr;
  logic [31:0] r_ref_addr;
  logic [31:0] r_total_sad;
  logic        r_err_timeout;
  logic        r_err_frame;
  logic [7:0]  r_res_row;
  logic [7:0]  r_res_col;
  logic [5:0]  r_res_mv_x;
  logic [5:0]  r_res_mv_y;
  logic [15:0] r_res_sad;

  logic w_accept;
  logic w_reject;
  logic w_capture;
  logic w_timeout;
  logic w_last_mb;

  assign w_last_mb = (r_row == c_row_last) && (r_col == c_col_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    me_start     = 1'b0;
    res_valid    = 1'b0;
    frame_done   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          if (frame_idx != 16'd0) begin
            w_accept     = 1'b1;
            w_state_next = S_LAUNCH;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        busy         = 1'b1;
        me_start     = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        // A done seen in the first WAIT cycle belongs to the previous MB.
        if ((r_wait_cnt != 32'd0) && me_done) begin
          w_capture    = 1'b1;
          w_state_next = S_EMIT;
        end else if (r_wait_cnt == c_wait_last) begin
          w_timeout    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        busy         = 1'b1;
        w_state_next = w_last_mb ? S_DONE : S_LAUNCH;
      end
      S_DONE: begin
        frame_done   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col         <= 8'd0;
      r_row         <= 8'd0;
      r_wait_cnt    <= 32'd0;
      r_frame_addr  <= 32'd0;
      r_ref_addr    <= 32'd0;
      r_total_sad   <= 32'd0;
      r_err_timeout <= 1'b0;
      r_err_frame   <= 1'b0;
      r_res_row     <= 8'd0;
      r_res_col     <= 8'd0;
      r_res_mv_x    <= 6'd0;
      r_res_mv_y    <= 6'd0;
      r_res_sad     <= 16'd0;
    end else begin
      if (w_accept) begin
        r_frame_addr  <= 32'(frame_idx) * c_frame_pixels;
        r_ref_addr    <= 32'(frame_idx - 16'd1) * c_frame_pixels;
        r_total_sad   <= 32'd0;
        r_err_timeout <= 1'b0;
        r_err_frame   <= 1'b0;
        r_col         <= 8'd0;
        r_row         <= 8'd0;
      end
      if (w_reject) begin
        r_err_frame <= 1'b1;
      end
      if (r_state == S_LAUNCH) begin
        r_wait_cnt <= 32'd0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 32'd1;
      end
      if (w_capture) begin
        r_res_row   <= r_row;
        r_res_col   <= r_col;
        r_res_mv_x  <= me_mv_x;
        r_res_mv_y  <= me_mv_y;
        r_res_sad   <= me_sad;
        r_total_sad <= r_total_sad + {16'd0, me_sad};
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if ((r_state == S_NEXT) && !w_last_mb) begin
        if (r_col == c_col_last) begin
          r_col <= 8'd0;
          r_row <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  assign total_sad           = r_total_sad;
  assign err_timeout         = r_err_timeout;
  assign err_frame           = r_err_frame;
  assign me_frame_start_addr = r_frame_addr;
  assign me_ref_start_addr   = r_ref_addr;
  assign me_mb_x             = {24'd0, r_col};
  assign me_mb_y             = {24'd0, r_row};
  assign res_mb_row          = r_res_row;
  assign res_mb_col          = r_res_col;
  assign res_mv_x            = r_res_mv_x;
  assign res_mv_y            = r_res_mv_y;
  assign res_sad             = r_res_sad;

endmodule
`default_nettype wire

// File: tb/tb_hexbs_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hexbs_frame_scheduler                                        |
// | Purpose  : Randomized bench for hexbs_frame_scheduler with an engine model |
// |            and a raster-order record scoreboard.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hexbs_frame_scheduler;

  localparam int W     = 352;
  localparam int H     = 240;
  localparam int COLS  = 22;
  localparam int N_MB  = 330;
  localparam int TMO   = 50000;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [5:0]  mvx;
    logic [5:0]  mvy;
    logic [15:0] sad;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [15:0] frame_idx;
  logic        busy, frame_done, err_timeout, err_frame, me_start, me_done;
  logic [31:0] total_sad, me_frame_start_addr, me_ref_start_addr, me_mb_x, me_mb_y;
  logic [5:0]  me_mv_x, me_mv_y, res_mv_x, res_mv_y;
  logic [15:0] me_sad, res_sad;
  logic        res_valid, res_ready;
  logic [7:0]  res_mb_row, res_mb_col;
  logic [209:0] all_out;

  always #5 clk = ~clk;

  hexbs_frame_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_idx(frame_idx),
    .busy(busy), .frame_done(frame_done), .total_sad(total_sad),
    .err_timeout(err_timeout), .err_frame(err_frame), .me_start(me_start),
    .me_frame_start_addr(me_frame_start_addr), .me_ref_start_addr(me_ref_start_addr),
    .me_mb_x(me_mb_x), .me_mb_y(me_mb_y), .me_mv_x(me_mv_x), .me_mv_y(me_mv_y),
    .me_sad(me_sad), .me_done(me_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_mb_row(res_mb_row), .res_mb_col(res_mb_col), .res_mv_x(res_mv_x),
    .res_mv_y(res_mv_y), .res_sad(res_sad)
  );

  assign all_out = {busy, frame_done, total_sad, err_timeout, err_frame, me_start,
                    me_frame_start_addr, me_ref_start_addr, me_mb_x, me_mb_y, res_valid,
                    res_mb_row, res_mb_col, res_mv_x, res_mv_y, res_sad};

  int total_cnt = 0;
  int bad_cnt   = 0;
  int eng_k     = 0;
  int start_cnt = 0;
  int rec_cnt   = 0;
  int done_cnt  = 0;
  int cyc       = 0;
  int due       = 0;
  int rdy_mode  = 0;
  bit eng_fixed = 1'b1;
  bit eng_hang  = 1'b0;
  bit eng_stale = 1'b0;
  bit eng_abort = 1'b0;
  bit stall_done = 1'b0;
  longint      exp_total = 0;
  logic [31:0] exp_faddr = 32'd0;
  logic [31:0] exp_raddr = 32'd0;
  rec_t        exp_q[$];

  // Engine model: answers each start after a latency, optionally with a stale done first.
  initial begin
    int   lat, rr, cc;
    rec_t r;
    me_done = 1'b0; me_sad = 16'd0; me_mv_x = 6'd0; me_mv_y = 6'd0;
    forever begin
      @(negedge clk);
      if (rst_n && me_start) begin
        rr = eng_k / COLS;
        cc = eng_k % COLS;
        r.row = 8'(rr);
        r.col = 8'(cc);
        total_cnt++;
        if (me_mb_x !== 32'(cc) || me_mb_y !== 32'(rr)) begin
          bad_cnt++;
          $display("FAIL mb_pos: got x=%0d y=%0d want x=%0d y=%0d", me_mb_x, me_mb_y, cc, rr);
        end
        total_cnt++;
        if (me_frame_start_addr !== exp_faddr || me_ref_start_addr !== exp_raddr) begin
          bad_cnt++;
          $display("FAIL me_addr: got %0d/%0d want %0d/%0d", me_frame_start_addr,
                   me_ref_start_addr, exp_faddr, exp_raddr);
        end
        eng_k++;
        start_cnt++;
        r.sad = eng_fixed ? 16'(rr * COLS + cc) : 16'($urandom);
        r.mvx = 6'($urandom);
        r.mvy = 6'($urandom);
        lat   = eng_fixed ? 5 : int'($urandom_range(3, 8));
        if (!eng_hang) begin
          exp_q.push_back(r);
          exp_total += longint'(r.sad);
        end
        @(negedge clk);
        if (eng_stale && !eng_hang && $urandom_range(0, 1) == 1) begin
          me_done = 1'b1; me_sad = ~r.sad; me_mv_x = ~r.mvx; me_mv_y = ~r.mvy;
        end
        if (!eng_hang) begin
          repeat (lat - 1) begin
            @(negedge clk);
            me_done = 1'b0;
          end
          me_done = 1'b1; me_sad = r.sad; me_mv_x = r.mvx; me_mv_y = r.mvy;
          @(negedge clk);
          me_done = 1'b0;
          if (!eng_abort) begin
            total_cnt++;
            if (res_valid !== 1'b1) begin
              bad_cnt++;
              $display("FAIL done_to_valid: got res_valid=%b want 1", res_valid);
            end
          end
        end
      end
    end
  end

  // Consumer: always ready, random, or a 10-cycle stall on the sixth record.
  initial begin
    int   s0;
    rec_t snap;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        res_ready = ($urandom_range(0, 3) != 0);
      end else if (rdy_mode == 2 && res_valid && rec_cnt == 5 && !stall_done) begin
        stall_done = 1'b1;
        res_ready  = 1'b0;
        s0   = start_cnt;
        snap = exp_q[0];
        repeat (10) @(posedge clk);
        #1;
        total_cnt++;
        if (start_cnt !== s0 || res_valid !== 1'b1) begin
          bad_cnt++;
          $display("FAIL stall_hold: got starts=%0d valid=%b want starts=%0d valid=1",
                   start_cnt, res_valid, s0);
        end
        total_cnt++;
        if ({res_mb_row, res_mb_col} !== {8'd0, 8'd5} || res_sad !== snap.sad) begin
          bad_cnt++;
          $display("FAIL stall_rec: got (%0d,%0d) sad=%0d want (0,5) sad=%0d",
                   res_mb_row, res_mb_col, res_sad, snap.sad);
        end
        res_ready = 1'b1;
      end else begin
        res_ready = (rdy_mode != 1) ? 1'b1 : res_ready;
      end
    end
  end

  // Scoreboard: records must match the model in raster order while valid.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (frame_done === 1'b1) done_cnt++;
        if (me_start === 1'b1) begin
          if (due != 0) begin
            total_cnt++;
            if (cyc != due) begin
              bad_cnt++;
              $display("FAIL hs_to_start: got cycle %0d want %0d", cyc, due);
            end
          end
          due = 0;
        end
        if (res_valid === 1'b1) begin
          total_cnt++;
          if (exp_q.size() == 0) begin
            bad_cnt++;
            $display("FAIL record: got (%0d,%0d) want no record", res_mb_row, res_mb_col);
          end else if ({res_mb_row, res_mb_col, res_mv_x, res_mv_y, res_sad} !== exp_q[0]) begin
            bad_cnt++;
            $display("FAIL record: got (%0d,%0d) mv=%0d,%0d sad=%0d want (%0d,%0d) mv=%0d,%0d sad=%0d",
                     res_mb_row, res_mb_col, res_mv_x, res_mv_y, res_sad, exp_q[0].row,
                     exp_q[0].col, exp_q[0].mvx, exp_q[0].mvy, exp_q[0].sad);
          end
          if (res_ready === 1'b1) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            rec_cnt++;
            if (rec_cnt < N_MB) due = cyc + 2;
          end
        end
      end
    end
  end

  task automatic prep_frame(input logic [15:0] idx);
    exp_faddr = 32'(idx) * 32'(W * H);
    exp_raddr = 32'(idx - 16'd1) * 32'(W * H);
    eng_k = 0; rec_cnt = 0; done_cnt = 0; due = 0; exp_total = 0;
    exp_q.delete();
  endtask

  task automatic start_frame(input logic [15:0] idx);
    @(negedge clk);
    frame_idx = idx;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; frame_idx = 16'd0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (all_out !== '0) begin
      bad_cnt++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (all_out !== '0) begin
      bad_cnt++;
      $display("FAIL idle_outputs: got %h want 0", all_out);
    end
  endtask

  task automatic test_basic_frame();
    bit ok; int n;
    prep_frame(16'd1);
    eng_fixed = 1'b1; eng_stale = 1'b0; rdy_mode = 0;
    start_frame(16'd1);
    total_cnt++;
    if (me_start !== 1'b1 || busy !== 1'b1) begin
      bad_cnt++;
      $display("FAIL start_latency: got me_start=%b busy=%b want 1 1", me_start, busy);
    end
    wait_frame_done(8000, ok, n);
    total_cnt++;
    if (!ok || n != N_MB * 8) begin
      bad_cnt++;
      $display("FAIL frame_cycles: got ok=%b n=%0d want %0d", ok, n, N_MB * 8);
    end
    total_cnt++;
    if (busy !== 1'b0 || total_sad !== 32'd54285) begin
      bad_cnt++;
      $display("FAIL basic_done: got busy=%b sad=%0d want 0 54285", busy, total_sad);
    end
    total_cnt++;
    if (me_frame_start_addr !== 32'd84480 || me_ref_start_addr !== 32'd0) begin
      bad_cnt++;
      $display("FAIL basic_addr: got %0d/%0d want 84480/0", me_frame_start_addr, me_ref_start_addr);
    end
    @(negedge clk); #1;
    total_cnt++;
    if (frame_done !== 1'b0 || done_cnt != 1 || rec_cnt != N_MB || eng_k != N_MB) begin
      bad_cnt++;
      $display("FAIL basic_counts: got fd=%b dones=%0d recs=%0d starts=%0d want 0 1 330 330",
               frame_done, done_cnt, rec_cnt, eng_k);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int n;
    prep_frame(16'd3);
    eng_fixed = 1'b0; eng_stale = 1'b1; rdy_mode = 2; stall_done = 1'b0;
    start_frame(16'd3);
    total_cnt++;
    if (me_frame_start_addr !== 32'd253440 || me_ref_start_addr !== 32'd168960) begin
      bad_cnt++;
      $display("FAIL idx3_addr: got %0d/%0d want 253440/168960", me_frame_start_addr, me_ref_start_addr);
    end
    wait_frame_done(10000, ok, n);
    total_cnt++;
    if (!ok || total_sad !== 32'(exp_total)) begin
      bad_cnt++;
      $display("FAIL bp_done: got ok=%b sad=%0d want 1 %0d", ok, total_sad, 32'(exp_total));
    end
    @(negedge clk); #1;
    total_cnt++;
    if (rec_cnt != N_MB || done_cnt != 1 || stall_done !== 1'b1) begin
      bad_cnt++;
      $display("FAIL bp_counts: got recs=%0d dones=%0d stall=%b want 330 1 1", rec_cnt, done_cnt, stall_done);
    end
    rdy_mode = 0; eng_stale = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok; int n;
    prep_frame(16'd2);
    eng_hang = 1'b1;
    start_frame(16'd2);
    wait_frame_done(TMO + 100, ok, n);
    total_cnt++;
    if (!ok || n != TMO + 1) begin
      bad_cnt++;
      $display("FAIL timeout_cycles: got ok=%b n=%0d want %0d", ok, n, TMO + 1);
    end
    total_cnt++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || total_sad !== 32'd0 || rec_cnt != 0) begin
      bad_cnt++;
      $display("FAIL timeout_state: got err=%b busy=%b sad=%0d recs=%0d want 1 0 0 0",
               err_timeout, busy, total_sad, rec_cnt);
    end
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b0 || err_timeout !== 1'b1) begin
      bad_cnt++;
      $display("FAIL timeout_sticky: got fd=%b err=%b want 0 1", frame_done, err_timeout);
    end
    eng_hang = 1'b0;
  endtask

  task automatic test_errors();
    bit ok; int n, s0;
    s0 = start_cnt;
    start_frame(16'd0);
    repeat (4) @(negedge clk);
    total_cnt++;
    if (err_frame !== 1'b1 || start_cnt != s0 || busy !== 1'b0 || err_timeout !== 1'b1) begin
      bad_cnt++;
      $display("FAIL idx0: got err_frame=%b starts=%0d busy=%b tmo=%b want 1 %0d 0 1",
               err_frame, start_cnt, busy, err_timeout, s0);
    end
    prep_frame(16'd5);
    eng_fixed = 1'b0; eng_stale = 1'b1; rdy_mode = 1;
    start_frame(16'd5);
    total_cnt++;
    if (err_timeout !== 1'b0 || err_frame !== 1'b0 || busy !== 1'b1) begin
      bad_cnt++;
      $display("FAIL err_clear: got tmo=%b frm=%b busy=%b want 0 0 1", err_timeout, err_frame, busy);
    end
    repeat (300) @(negedge clk);
    start_frame(16'd0);
    start_frame(16'd9);
    wait_frame_done(12000, ok, n);
    total_cnt++;
    if (!ok || total_sad !== 32'(exp_total) || err_frame !== 1'b0) begin
      bad_cnt++;
      $display("FAIL midstart_done: got ok=%b sad=%0d frm=%b want 1 %0d 0",
               ok, total_sad, err_frame, 32'(exp_total));
    end
    @(negedge clk); #1;
    total_cnt++;
    if (rec_cnt != N_MB || done_cnt != 1) begin
      bad_cnt++;
      $display("FAIL midstart_counts: got recs=%0d dones=%0d want 330 1", rec_cnt, done_cnt);
    end
    rdy_mode = 0; eng_stale = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit ok; int n;
    prep_frame(16'd4);
    eng_fixed = 1'b1;
    start_frame(16'd4);
    for (int i = 0; i < 4000 && eng_k < 7 * COLS + 4; i++) begin
      @(negedge clk); #1;
    end
    total_cnt++;
    if (eng_k != 7 * COLS + 4 || me_start !== 1'b1 || me_mb_y !== 32'd7 || me_mb_x !== 32'd3) begin
      bad_cnt++;
      $display("FAIL reach_mb73: got k=%0d start=%b (%0d,%0d) want %0d 1 (7,3)",
               eng_k, me_start, me_mb_y, me_mb_x, 7 * COLS + 4);
    end
    eng_abort = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (all_out !== '0) begin
      bad_cnt++;
      $display("FAIL async_reset: got %h want 0", all_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    total_cnt++;
    if (done_cnt != 0) begin
      bad_cnt++;
      $display("FAIL abort_no_done: got dones=%0d want 0", done_cnt);
    end
    prep_frame(16'd2);
    eng_abort = 1'b0;
    start_frame(16'd2);
    total_cnt++;
    if (me_mb_x !== 32'd0 || me_mb_y !== 32'd0 || total_sad !== 32'd0) begin
      bad_cnt++;
      $display("FAIL restart: got (%0d,%0d) sad=%0d want (0,0) 0", me_mb_y, me_mb_x, total_sad);
    end
    wait_frame_done(8000, ok, n);
    total_cnt++;
    if (!ok || total_sad !== 32'd54285) begin
      bad_cnt++;
      $display("FAIL restart_sad: got ok=%b sad=%0d want 1 54285", ok, total_sad);
    end
    @(negedge clk); #1;
    total_cnt++;
    if (rec_cnt != N_MB || done_cnt != 1) begin
      bad_cnt++;
      $display("FAIL restart_counts: got recs=%0d dones=%0d want 330 1", rec_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_timeout();
    test_errors();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
